// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Receives a program as a stream of bytes and writes it, one 32-bit
//   little-endian word at a time, into instruction memory starting at
//   BASE_ADDRESS. The CPU is held in reset until a load completes.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   start_i         begin a load (honoured in IDLE, DONE, ERROR only)
//   word_count_i    number of words to load, sampled with start_i
//   byte_i          incoming program byte
//   byte_valid_i    byte_i holds a valid byte
//   byte_ready_o    loader accepts a byte this cycle
//   Write_Enable_o  one-cycle instruction-memory write strobe
//   Address_o       byte address of the word being written (registered)
//   Write_Data_o    assembled instruction word (registered)
//   cpu_hold_o      holds the CPU in reset while memory is not valid
//   done_o          load completed successfully
//   error_o         last load request was rejected
//   state_o         current FSM state, for debug and checkers
//
// Byte handshake: a byte moves on a rising edge only when byte_valid_i and
// byte_ready_o are both 1. byte_ready_o depends on the state alone, so it
// is stable for the whole cycle and never depends on byte_valid_i.
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int                    MEMORY_DEPTH = 32,
   parameter int                    DATA_WIDTH   = 32,
   // Low 17 bits must be zero so Address_o[16:2] reads back as the word index.
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [15:0]           word_count_i,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  Write_Enable_o,
   output logic [DATA_WIDTH-1:0] Address_o,
   output logic [DATA_WIDTH-1:0] Write_Data_o,
   output logic                  cpu_hold_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [2:0]            state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam logic [16:0] DEPTH_W = 17'(MEMORY_DEPTH);

   state_t                  state_q, state_d;
   logic [15:0]             word_idx_q, word_idx_d;
   logic [15:0]             count_q, count_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [23:0]             asm_q, asm_d;     // bytes 0..2 of the current word
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    hold_q, hold_d;
   logic                    count_ok;

   assign count_ok = (word_count_i != 16'd0) && ({1'b0, word_count_i} <= DEPTH_W);

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      error_d    = error_q;
      hold_d     = hold_q;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_i) begin
               done_d = 1'b0;
               hold_d = 1'b1;
               if (count_ok) begin
                  state_d    = RECV;
                  word_idx_d = 16'd0;
                  byte_idx_d = 2'd0;
                  asm_d      = 24'd0;
                  count_d    = word_count_i;
                  error_d    = 1'b0;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end
         end

         RECV: begin
            if (byte_valid_i) begin
               if (byte_idx_q == 2'd3) begin
                  // Final byte: latch the whole word and its address so both
                  // are stable throughout the WRITE cycle and held afterwards.
                  wdata_d = DATA_WIDTH'({byte_i, asm_q});
                  addr_d  = BASE_ADDRESS + (DATA_WIDTH'(word_idx_q) << 2);
                  state_d = WRITE;
               end else begin
                  case (byte_idx_q)
                     2'd0:    asm_d[7:0]   = byte_i;
                     2'd1:    asm_d[15:8]  = byte_i;
                     default: asm_d[23:16] = byte_i;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end

         WRITE: begin
            if (word_idx_q == count_q - 16'd1) begin
               state_d = DONE;
               done_d  = 1'b1;
               hold_d  = 1'b0;
            end else begin
               word_idx_d = word_idx_q + 16'd1;
               byte_idx_d = 2'd0;
               asm_d      = 24'd0;
               state_d    = RECV;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         word_idx_q <= 16'd0;
         count_q    <= 16'd0;
         byte_idx_q <= 2'd0;
         asm_q      <= 24'd0;
         addr_q     <= BASE_ADDRESS;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         hold_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         error_q    <= error_d;
         hold_q     <= hold_d;
      end
   end

   assign byte_ready_o   = (state_q == RECV);
   assign Write_Enable_o = (state_q == WRITE);
   assign Address_o      = addr_q;
   assign Write_Data_o   = wdata_q;
   assign cpu_hold_o     = hold_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Random program bytes are fed with
//   random gaps; expected memory writes are derived from the byte list by
//   packing each group of four bytes little-endian at BASE + 4*i.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [15:0] word_count_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        write_enable_o;
  logic [31:0] address_o;
  logic [31:0] write_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        error_o;
  logic [2:0]  state_o;

  int checks = 0;
  int passed = 0;

  logic [7:0]  prog_bytes[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] wr_addr_q[$];

  int we_run      = 0;
  int we_run_max  = 0;
  int ready_in_we = 0;
  int lat_err     = 0;
  bit timeout     = 0;

  program_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .word_count_i   (word_count_i),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .Write_Enable_o (write_enable_o),
    .Address_o      (address_o),
    .Write_Data_o   (write_data_o),
    .cpu_hold_o     (cpu_hold_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .state_o        (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- write capture ----------------
  always @(negedge clk) begin
    if (write_enable_o === 1'b1) begin
      wr_data_q.push_back(write_data_o);
      wr_addr_q.push_back(address_o);
      we_run++;
      if (we_run > we_run_max) we_run_max = we_run;
      if (byte_ready_o !== 1'b0) ready_in_we++;
    end else begin
      we_run = 0;
    end
  end

  // ---------------- reference model ----------------
  task automatic fill_bytes(input int count);
    prog_bytes.delete();
    for (int i = 0; i < 4 * count; i++) prog_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic build_expected(input int count);
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(32'(prog_bytes[4*i])
                      + (32'(prog_bytes[4*i+1]) << 8)
                      + (32'(prog_bytes[4*i+2]) << 16)
                      + (32'(prog_bytes[4*i+3]) << 24));
      exp_addr_q.push_back(BASE + 32'(4 * i));
    end
  endtask

  task automatic clear_capture();
    wr_data_q.delete();
    wr_addr_q.delete();
    we_run_max  = 0;
    ready_in_we = 0;
  endtask

  // ---------------- driver ----------------
  // Issues start, then offers prog_bytes with random gaps. Notes any cycle
  // after a 4th-byte transfer where the strobe is missing or ready is high.
  task automatic drive_load(input int count, input int gap_pct,
                            input bit junk_write, input bit junk_start);
    int idx;
    int nb;
    int cyc;
    bit expect_we;
    nb = 4 * count;
    idx = 0;
    cyc = 0;
    expect_we = 0;
    lat_err = 0;
    timeout = 0;
    @(negedge clk);
    start_i = 1'b1;
    word_count_i = 16'(count);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    while ((idx < nb || expect_we) && !timeout) begin
      if (expect_we) begin
        if (write_enable_o !== 1'b1 || byte_ready_o !== 1'b0) lat_err++;
        expect_we = 0;
      end
      byte_valid_i = 1'b0;
      byte_i = 8'($urandom_range(0, 255));
      start_i = 1'b0;
      if (idx < nb) begin
        if (junk_start && $urandom_range(0, 3) == 0) begin
          start_i = 1'b1;
          word_count_i = 16'($urandom_range(0, 40));
        end
        if (byte_ready_o === 1'b1) begin
          if ($urandom_range(0, 99) >= gap_pct) begin
            byte_valid_i = 1'b1;
            byte_i = prog_bytes[idx];
          end
        end else if (junk_write) begin
          byte_valid_i = 1'b1;
        end
      end
      if (byte_valid_i && byte_ready_o === 1'b1) begin
        if (idx % 4 == 3) expect_we = 1;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc > 5000) timeout = 1;
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (byte_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", byte_ready_o); else passed++;
    checks++; if (write_enable_o !== 1'b0) $display("FAIL reset_we: got %b want 0", write_enable_o); else passed++;
    checks++; if (address_o !== BASE) $display("FAIL reset_addr: got %h want %h", address_o, BASE); else passed++;
    checks++; if (write_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", write_data_o); else passed++;
    checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else passed++;
    checks++; if (error_o !== 1'b0) $display("FAIL reset_error: got %b want 0", error_o); else passed++;
    checks++; if (cpu_hold_o !== 1'b1) $display("FAIL reset_hold: got %b want 1", cpu_hold_o); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] fixed [8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    prog_bytes.delete();
    for (int i = 0; i < 8; i++) prog_bytes.push_back(fixed[i]);
    clear_capture();
    drive_load(2, 0, 1'b0, 1'b0);
    checks++; if (timeout) $display("FAIL basic_timeout: load did not finish"); else passed++;
    checks++; if (wr_data_q.size() !== 2) $display("FAIL basic_nwrites: got %0d want 2", wr_data_q.size()); else passed++;
    if (wr_data_q.size() == 2) begin
      checks++; if (wr_data_q[0] !== 32'h0000_0513 || wr_addr_q[0] !== 32'h0040_0000)
        $display("FAIL basic_w0: got %h@%h want 00000513@00400000", wr_data_q[0], wr_addr_q[0]); else passed++;
      checks++; if (wr_data_q[1] !== 32'h0010_0593 || wr_addr_q[1] !== 32'h0040_0004)
        $display("FAIL basic_w1: got %h@%h want 00100593@00400004", wr_data_q[1], wr_addr_q[1]); else passed++;
    end
    checks++; if (lat_err !== 0) $display("FAIL basic_latency: got %0d late/early strobes want 0", lat_err); else passed++;
    checks++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0)
      $display("FAIL basic_done: got done=%b hold=%b want done=1 hold=0", done_o, cpu_hold_o); else passed++;
    checks++; if (error_o !== 1'b0) $display("FAIL basic_error: got %b want 0", error_o); else passed++;
    // Outputs hold their last written value after the load.
    checks++; if (write_data_o !== 32'h0010_0593 || address_o !== 32'h0040_0004)
      $display("FAIL basic_hold: got %h@%h want 00100593@00400004", write_data_o, address_o); else passed++;
  endtask

  task automatic test_errors();
    int bad [2] = '{0, 33};
    for (int k = 0; k < 2; k++) begin
      clear_capture();
      @(negedge clk);
      start_i = 1'b1;
      word_count_i = 16'(bad[k]);
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (error_o !== 1'b1 || done_o !== 1'b0 || cpu_hold_o !== 1'b1)
        $display("FAIL err_flags_%0d: got err=%b done=%b hold=%b want 1 0 1", bad[k], error_o, done_o, cpu_hold_o); else passed++;
      checks++; if (wr_data_q.size() !== 0 || byte_ready_o !== 1'b0)
        $display("FAIL err_nowrite_%0d: got %0d writes ready=%b want 0 writes ready=0", bad[k], wr_data_q.size(), byte_ready_o); else passed++;
    end
    fill_bytes(1);
    build_expected(1);
    clear_capture();
    drive_load(1, 30, 1'b0, 1'b0);
    checks++; if (timeout || wr_data_q.size() !== 1) $display("FAIL err_recover_n: got %0d writes want 1", wr_data_q.size()); else passed++;
    if (wr_data_q.size() == 1) begin
      checks++; if (wr_data_q[0] !== exp_q[0] || wr_addr_q[0] !== exp_addr_q[0])
        $display("FAIL err_recover_w: got %h@%h want %h@%h", wr_data_q[0], wr_addr_q[0], exp_q[0], exp_addr_q[0]); else passed++;
    end
    checks++; if (error_o !== 1'b0 || done_o !== 1'b1) $display("FAIL err_recover_flags: got err=%b done=%b want 0 1", error_o, done_o); else passed++;
  endtask

  task automatic test_gaps();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      fill_bytes(n);
      build_expected(n);
      clear_capture();
      drive_load(n, 45, 1'b1, 1'b0);
      checks++; if (timeout || wr_data_q.size() !== n)
        $display("FAIL gaps_n_%0d: got %0d writes want %0d", it, wr_data_q.size(), n); else passed++;
      if (wr_data_q.size() == n) begin
        for (int i = 0; i < n; i++) begin
          checks++; if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== exp_addr_q[i])
            $display("FAIL gaps_w_%0d_%0d: got %h@%h want %h@%h", it, i, wr_data_q[i], wr_addr_q[i], exp_q[i], exp_addr_q[i]); else passed++;
        end
      end
      checks++; if (lat_err !== 0 || we_run_max !== 1 || ready_in_we !== 0)
        $display("FAIL gaps_strobe_%0d: got lat=%0d run=%0d rdy=%0d want 0 1 0", it, lat_err, we_run_max, ready_in_we); else passed++;
    end
  endtask

  task automatic test_reset_midload();
    clear_capture();
    @(negedge clk);
    start_i = 1'b1;
    word_count_i = 16'd1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    byte_valid_i = 1'b1;
    byte_i = 8'hA1;
    @(posedge clk);
    @(negedge clk);
    byte_i = 8'hB2;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start_i = 1'b1;
    byte_i = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    checks++; if (write_enable_o !== 1'b0 || byte_ready_o !== 1'b0)
      $display("FAIL midrst_we: got we=%b ready=%b want 0 0", write_enable_o, byte_ready_o); else passed++;
    checks++; if (address_o !== BASE || write_data_o !== 32'h0)
      $display("FAIL midrst_regs: got %h@%h want 00000000@%h", write_data_o, address_o, BASE); else passed++;
    checks++; if (done_o !== 1'b0 || error_o !== 1'b0 || cpu_hold_o !== 1'b1)
      $display("FAIL midrst_flags: got done=%b err=%b hold=%b want 0 0 1", done_o, error_o, cpu_hold_o); else passed++;
    reset = 1'b0;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_data_q.size() !== 0) $display("FAIL midrst_nowrite: got %0d writes want 0", wr_data_q.size()); else passed++;
    fill_bytes(1);
    build_expected(1);
    drive_load(1, 20, 1'b1, 1'b0);
    checks++; if (timeout || wr_data_q.size() !== 1) $display("FAIL midrst_fresh_n: got %0d writes want 1", wr_data_q.size()); else passed++;
    if (wr_data_q.size() == 1) begin
      checks++; if (wr_data_q[0] !== exp_q[0] || wr_addr_q[0] !== BASE)
        $display("FAIL midrst_fresh_w: got %h@%h want %h@%h", wr_data_q[0], wr_addr_q[0], exp_q[0], BASE); else passed++;
    end
  endtask

  task automatic test_full();
    int bad_words;
    fill_bytes(32);
    build_expected(32);
    clear_capture();
    drive_load(32, 20, 1'b1, 1'b1);
    checks++; if (timeout || wr_data_q.size() !== 32)
      $display("FAIL full_n: got %0d writes want 32", wr_data_q.size()); else passed++;
    bad_words = 0;
    if (wr_data_q.size() == 32) begin
      for (int i = 0; i < 32; i++)
        if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== exp_addr_q[i]) bad_words++;
      checks++; if (bad_words !== 0) $display("FAIL full_words: got %0d wrong words want 0", bad_words); else passed++;
      checks++; if (wr_addr_q[31] !== 32'h0040_007C)
        $display("FAIL full_last_addr: got %h want 0040007c", wr_addr_q[31]); else passed++;
    end
    checks++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0 || error_o !== 1'b0)
      $display("FAIL full_flags: got done=%b hold=%b err=%b want 1 0 0", done_o, cpu_hold_o, error_o); else passed++;
    checks++; if (lat_err !== 0 || we_run_max !== 1 || ready_in_we !== 0)
      $display("FAIL full_strobe: got lat=%0d run=%0d rdy=%0d want 0 1 0", lat_err, we_run_max, ready_in_we); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    word_count_i = 16'd0;
    byte_i = 8'd0;
    byte_valid_i = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_gaps();
    test_reset_midload();
    test_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, is the instruction-memory capacity in words.
REQ-002 Parameter DATA_WIDTH, default 32, is the instruction and address width.
REQ-003 Parameter BASE_ADDRESS, default 32'h0040_0000, is the byte address of word 0; bits [16:0] shall be zero.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  begin a load; sampled every cycle.
REQ-007 word_count_i  input  16  number of instruction words to load; sampled with start_i.
REQ-008 byte_i  input  8  incoming program byte.
REQ-009 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-010 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-011 Write_Enable_o  output  1  one-cycle write strobe to instruction memory.
REQ-012 Address_o  output  DATA_WIDTH  byte address of the word being written.
REQ-013 Write_Data_o  output  DATA_WIDTH  assembled instruction word.
REQ-014 cpu_hold_o  output  1  holds the CPU in reset while memory contents are not valid.
REQ-015 done_o  output  1  load completed successfully.
REQ-016 error_o  output  1  rejected load request.

Function
REQ-017 The FSM states shall be IDLE, RECV, WRITE, DONE and ERROR.
REQ-018 A byte transfer shall occur on a rising edge only when byte_valid_i=1 and byte_ready_o=1; byte_valid_i while byte_ready_o=0 is ignored.
REQ-019 byte_ready_o shall be 1 only in RECV; it is 0 in every other state.
REQ-020 In IDLE, DONE or ERROR, start_i=1 with word_count_i in 1..MEMORY_DEPTH: clear the word index, byte index and assembly register; clear done_o and error_o; set cpu_hold_o=1; go to RECV.
REQ-021 In IDLE, DONE or ERROR, start_i=1 with word_count_i=0 or word_count_i>MEMORY_DEPTH: set error_o=1, done_o=0 and cpu_hold_o=1; go to ERROR; issue no write.
REQ-022 start_i shall be ignored in RECV and WRITE.
REQ-023 Byte assembly shall be little-endian: transferred byte k (0..3) lands in Write_Data_o bits [8k+7:8k].
REQ-024 The transfer of byte 3 shall move the FSM to WRITE on the same edge.
REQ-025 In WRITE, Write_Enable_o shall be 1 for exactly one cycle.
REQ-026 In WRITE, Address_o shall equal BASE_ADDRESS + 4*word_index, so that Address_o[16:2] equals word_index.
REQ-027 Latency: the edge that transfers byte 3 shall make Write_Enable_o high in the following cycle.
REQ-028 On leaving WRITE, if word_index = word_count-1 the FSM goes to DONE; otherwise word_index increments and the FSM returns to RECV with byte index 0.
REQ-029 In DONE, done_o shall be 1 and cpu_hold_o 0, holding until reset or a new start_i.
REQ-030 Address_o and Write_Data_o are registered and shall hold their last value whenever Write_Enable_o=0.
REQ-031 word_index arithmetic shall be width-safe: the largest address issued is BASE_ADDRESS + 4*(MEMORY_DEPTH-1), with no wrap.

Reset
REQ-032 reset=1 on a rising edge shall force: IDLE, byte_ready_o=0, Write_Enable_o=0, Address_o=BASE_ADDRESS, Write_Data_o=0, done_o=0, error_o=0, cpu_hold_o=1.
REQ-033 reset shall take priority over start_i and byte transfers.
REQ-034 Reset mid-load shall discard any partially assembled word and shall produce no write strobe in the cycle after reset.

Verification
REQ-035 start, count=2; bytes 13,05,00,00,93,05,10,00 with valid held high -> writes 32'h00000513@32'h00400000, then 32'h00100593@32'h00400004; done_o=1, cpu_hold_o=0.
REQ-036 Byte 3 transferred at edge N -> Write_Enable_o high exactly during cycle N+1, byte_ready_o=0 in that cycle.
REQ-037 start with count=0, then start with count=33 -> error_o=1 each time, no Write_Enable_o, cpu_hold_o=1; a later start with count=1 leaves ERROR normally.
REQ-038 Gaps in byte_valid_i, plus valid asserted during WRITE -> gap bytes and the byte offered during WRITE are not consumed, and the assembled word is unchanged.
REQ-039 reset asserted after 2 of 4 bytes -> reset values next cycle; a fresh load writes the correct word at BASE_ADDRESS.
REQ-040 count=32, full load -> 32 strobes, last Address_o=32'h0040007C, done_o=1; start_i pulses during RECV are ignored.
